// File: rtl/mc14500b_loader.sv
// mc14500b_loader: feeds a program stream into the MC14500B core one word at a
// time, releases the core into execution with a timed reset, and reports NOPF
// flags while the program runs.
module mc14500b_loader #(
    parameter int DEPTH      = 256,
    parameter int RST_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [11:0]                s_data,
    input  logic                       s_last,
    output logic                       core_rst,
    output logic                       core_program_write,
    output logic [11:0]                core_program_cmd,
    input  logic [3:0]                 core_opcode,
    output logic                       busy,
    output logic                       running,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded,
    output logic                       overflow,
    output logic                       flag_f
);

    localparam int WL_W = $clog2(DEPTH + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    localparam logic [WL_W-1:0] DEPTH_W = WL_W'(DEPTH);
    localparam logic [WL_W-1:0] WL_ONE  = WL_W'(1);
    localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
    localparam logic [3:0]      OP_NOPF = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_START,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       cmd_q, cmd_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic              ovf_q, ovf_d;
    logic              last_q, last_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic              flag_q, flag_d;

    // Next-state logic: word acceptance, overflow handling, start-of-run timing.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        wl_d      = wl_q;
        ovf_d     = ovf_q;
        last_d    = last_q;
        rst_cnt_d = RC_INIT;
        flag_d    = (state_q == ST_RUN) && (core_opcode == OP_NOPF);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    wl_d    = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    if (wl_q < DEPTH_W) begin
                        cmd_d   = s_data;
                        wl_d    = wl_q + WL_ONE;
                        last_d  = s_last;
                        state_d = ST_WRITE;
                    end else begin
                        // Core memory is full: drop the word, but still honour
                        // the end-of-program marker so the core gets started.
                        ovf_d = 1'b1;
                        if (s_last) begin
                            state_d = ST_START;
                        end
                    end
                end
            end
            ST_WRITE: begin
                state_d = last_q ? ST_START : ST_LOAD;
            end
            ST_START: begin
                // The counter is preloaded outside START and counts the
                // remaining reset cycles down to the last one.
                if (rst_cnt_q <= RC_ONE) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_ONE;
                end
            end
            ST_RUN: begin
                // Reload without resetting the core first.
                if (start) begin
                    state_d = ST_LOAD;
                    wl_d    = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs toward the stream source and the core.
    always_comb begin
        s_ready            = 1'b0;
        core_rst           = 1'b0;
        core_program_write = 1'b0;
        busy               = 1'b0;
        running            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_rst = 1'b1;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                core_program_write = 1'b1;
                busy               = 1'b1;
            end
            ST_START: begin
                core_rst = 1'b1;
                busy     = 1'b1;
            end
            ST_RUN: begin
                running = 1'b1;
            end
            default: begin
                core_rst = 1'b1;
            end
        endcase
    end

    assign core_program_cmd = cmd_q;
    assign words_loaded     = wl_q;
    assign overflow         = ovf_q;
    assign flag_f           = flag_q;

    // Register bank with synchronous reset that abandons any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            wl_q      <= '0;
            ovf_q     <= 1'b0;
            last_q    <= 1'b0;
            rst_cnt_q <= RC_INIT;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            wl_q      <= wl_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
            rst_cnt_q <= rst_cnt_d;
            flag_q    <= flag_d;
        end
    end

endmodule
